// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage RV32I core.
// Holds the EX-stage copy of the decoded instruction and detects load-use
// hazards against the instruction currently in ID.
// Optional feature: define ID_EX_PERF_CNT_EN to add bubble/flush counters
// (o_bubble_cnt, o_flush_cnt).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ID_valid,
  input  logic [XLEN-1:0]   i_ID_pc,
  input  logic [XLEN-1:0]   i_ID_rdata1,
  input  logic [XLEN-1:0]   i_ID_rdata2,
  input  logic [XLEN-1:0]   i_ID_imm,
  input  logic [4:0]        i_ID_rnum1,
  input  logic [4:0]        i_ID_rnum2,
  input  logic              i_ID_use_rs1,
  input  logic              i_ID_use_rs2,
  input  logic [4:0]        i_ID_wnum,
  input  logic              i_ID_wen,
  input  logic              i_ID_memRead,
  input  logic              i_ID_memWrite,
  input  logic [CTRL_W-1:0] i_ID_ctrl,
  input  logic              i_hold,
  input  logic              i_flush,
  output logic              o_EX_valid,
  output logic [XLEN-1:0]   o_EX_pc,
  output logic [XLEN-1:0]   o_EX_rdata1,
  output logic [XLEN-1:0]   o_EX_rdata2,
  output logic [XLEN-1:0]   o_EX_imm,
  output logic [4:0]        o_EX_rnum1,
  output logic [4:0]        o_EX_rnum2,
  output logic [4:0]        o_EX_wnum,
  output logic              o_EX_wen,
  output logic              o_EX_memRead,
  output logic              o_EX_memWrite,
  output logic [CTRL_W-1:0] o_EX_ctrl,
  output logic              o_stall_ID
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       o_bubble_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rnum1;
    logic [4:0]        rnum2;
    logic [4:0]        wnum;
    logic              wen;
    logic              memRead;
    logic              memWrite;
    logic [CTRL_W-1:0] ctrl;
  } exStage_t;

  exStage_t stage_q;
  exStage_t stage_d;
  logic     hazard;
  logic     loadInEx;
  logic     rs1Match;
  logic     rs2Match;

  // Load-use detection: a store that only needs the load result as store data
  // is left alone because that value is forwarded later, from WB to MEM.
  always_comb begin
    loadInEx = stage_q.valid & stage_q.memRead & (stage_q.wnum != 5'd0);
    rs1Match = i_ID_use_rs1 & (i_ID_rnum1 == stage_q.wnum);
    rs2Match = i_ID_use_rs2 & (i_ID_rnum2 == stage_q.wnum) & ~i_ID_memWrite;
    hazard   = loadInEx & i_ID_valid & ~i_flush & (rs1Match | rs2Match);
  end

  assign o_stall_ID = hazard;

  // Next stage contents: hold beats flush, and flush or hazard load a bubble.
  always_comb begin
    stage_d = stage_q;
    if (!i_hold) begin
      if (i_flush || hazard) begin
        stage_d = '0;
      end else begin
        stage_d.valid    = i_ID_valid;
        stage_d.pc       = i_ID_pc;
        stage_d.rdata1   = i_ID_rdata1;
        stage_d.rdata2   = i_ID_rdata2;
        stage_d.imm      = i_ID_imm;
        stage_d.rnum1    = i_ID_rnum1;
        stage_d.rnum2    = i_ID_rnum2;
        stage_d.wnum     = i_ID_wnum;
        stage_d.wen      = i_ID_wen;
        stage_d.memRead  = i_ID_memRead;
        stage_d.memWrite = i_ID_memWrite;
        stage_d.ctrl     = i_ID_ctrl;
      end
    end
  end

  // Pipeline register; reset leaves the stage holding a bubble.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_EX_valid    = stage_q.valid;
  assign o_EX_pc       = stage_q.pc;
  assign o_EX_rdata1   = stage_q.rdata1;
  assign o_EX_rdata2   = stage_q.rdata2;
  assign o_EX_imm      = stage_q.imm;
  assign o_EX_rnum1    = stage_q.rnum1;
  assign o_EX_rnum2    = stage_q.rnum2;
  assign o_EX_wnum     = stage_q.wnum;
  assign o_EX_wen      = stage_q.wen;
  assign o_EX_memRead  = stage_q.memRead;
  assign o_EX_memWrite = stage_q.memWrite;
  assign o_EX_ctrl     = stage_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbleCnt_q;
  logic [31:0] flushCnt_q;

  // Count bubbles actually loaded; frozen edges are not counted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bubbleCnt_q <= 32'd0;
      flushCnt_q  <= 32'd0;
    end else if (!i_hold) begin
      if (i_flush) begin
        flushCnt_q <= flushCnt_q + 32'd1;
      end else if (hazard) begin
        bubbleCnt_q <= bubbleCnt_q + 32'd1;
      end
    end
  end

  assign o_bubble_cnt = bubbleCnt_q;
  assign o_flush_cnt  = flushCnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for the ID/EX register and load-use logic.
module tb_id_ex_stage;

  logic        clk;
  logic        rstn;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idRdata1;
  logic [31:0] idRdata2;
  logic [31:0] idImm;
  logic [4:0]  idRnum1;
  logic [4:0]  idRnum2;
  logic        idUseRs1;
  logic        idUseRs2;
  logic [4:0]  idWnum;
  logic        idWen;
  logic        idMemRead;
  logic        idMemWrite;
  logic [7:0]  idCtrl;
  logic        hold;
  logic        flush;

  logic        exValid;
  logic [31:0] exPc;
  logic [31:0] exRdata1;
  logic [31:0] exRdata2;
  logic [31:0] exImm;
  logic [4:0]  exRnum1;
  logic [4:0]  exRnum2;
  logic [4:0]  exWnum;
  logic        exWen;
  logic        exMemRead;
  logic        exMemWrite;
  logic [7:0]  exCtrl;
  logic        stallId;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbleCnt;
  logic [31:0] flushCnt;
`endif

  int compareCount;
  int mismatchCount;

  id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_ID_valid    (idValid),
    .i_ID_pc       (idPc),
    .i_ID_rdata1   (idRdata1),
    .i_ID_rdata2   (idRdata2),
    .i_ID_imm      (idImm),
    .i_ID_rnum1    (idRnum1),
    .i_ID_rnum2    (idRnum2),
    .i_ID_use_rs1  (idUseRs1),
    .i_ID_use_rs2  (idUseRs2),
    .i_ID_wnum     (idWnum),
    .i_ID_wen      (idWen),
    .i_ID_memRead  (idMemRead),
    .i_ID_memWrite (idMemWrite),
    .i_ID_ctrl     (idCtrl),
    .i_hold        (hold),
    .i_flush       (flush),
    .o_EX_valid    (exValid),
    .o_EX_pc       (exPc),
    .o_EX_rdata1   (exRdata1),
    .o_EX_rdata2   (exRdata2),
    .o_EX_imm      (exImm),
    .o_EX_rnum1    (exRnum1),
    .o_EX_rnum2    (exRnum2),
    .o_EX_wnum     (exWnum),
    .o_EX_wen      (exWen),
    .o_EX_memRead  (exMemRead),
    .o_EX_memWrite (exMemWrite),
    .o_EX_ctrl     (exCtrl),
    .o_stall_ID    (stallId)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .o_bubble_cnt  (bubbleCnt),
    .o_flush_cnt   (flushCnt)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one decoded instruction into ID; data fields derived from the PC.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2,
                               input logic [4:0] wn, input logic we,
                               input logic mr, input logic mw,
                               input logic [7:0] ctrl);
    idValid    = v;
    idPc       = pc;
    idRdata1   = pc + 32'h1000;
    idRdata2   = pc + 32'h2000;
    idImm      = pc + 32'h4;
    idRnum1    = r1;
    idRnum2    = r2;
    idUseRs1   = u1;
    idUseRs2   = u2;
    idWnum     = wn;
    idWen      = we;
    idMemRead  = mr;
    idMemWrite = mw;
    idCtrl     = ctrl;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    clk   = 1'b0;
    rstn  = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    #2;
    checkOutput("rst_valid", 32'(exValid), 32'd0);
    checkOutput("rst_pc", exPc, 32'd0);
    checkOutput("rst_wnum", 32'(exWnum), 32'd0);
    checkOutput("rst_memRead", 32'(exMemRead), 32'd0);
    checkOutput("rst_stall", 32'(stallId), 32'd0);
    #10 rstn = 1'b1;

    // add x3,x1,x2
    applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 8'h01);
    #1 checkOutput("add_nostall", 32'(stallId), 32'd0);
    tick();
    checkOutput("add_valid", 32'(exValid), 32'd1);
    checkOutput("add_wnum", 32'(exWnum), 32'd3);
    checkOutput("add_rnum1", 32'(exRnum1), 32'd1);
    checkOutput("add_rnum2", 32'(exRnum2), 32'd2);
    checkOutput("add_pc", exPc, 32'h100);
    checkOutput("add_rdata1", exRdata1, 32'h1100);
    checkOutput("add_rdata2", exRdata2, 32'h2100);
    checkOutput("add_imm", exImm, 32'h104);
    checkOutput("add_ctrl", 32'(exCtrl), 32'h01);
    checkOutput("add_wen", 32'(exWen), 32'd1);

    // lw x5,0(x1)
    applyStimulus(1'b1, 32'h104, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    #1 checkOutput("lw_nostall", 32'(stallId), 32'd0);
    tick();
    checkOutput("lw_memRead", 32'(exMemRead), 32'd1);
    checkOutput("lw_wnum", 32'(exWnum), 32'd5);

    // add x6,x5,x7 right behind the load: one bubble, then captured
    applyStimulus(1'b1, 32'h108, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'h01);
    #1 checkOutput("lu_stall", 32'(stallId), 32'd1);
    tick();
    checkOutput("lu_bub_valid", 32'(exValid), 32'd0);
    checkOutput("lu_bub_wen", 32'(exWen), 32'd0);
    checkOutput("lu_bub_memRead", 32'(exMemRead), 32'd0);
    checkOutput("lu_bub_wnum", 32'(exWnum), 32'd0);
    checkOutput("lu_bub_pc", exPc, 32'd0);
    checkOutput("lu_stall_clear", 32'(stallId), 32'd0);
    tick();
    checkOutput("lu_cap_valid", 32'(exValid), 32'd1);
    checkOutput("lu_cap_wnum", 32'(exWnum), 32'd6);
    checkOutput("lu_cap_rnum1", 32'(exRnum1), 32'd5);
    checkOutput("lu_cap_pc", exPc, 32'h108);

    // lw x5 then sw x5,0(x8): rs2-only match, no stall
    applyStimulus(1'b1, 32'h10c, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    applyStimulus(1'b1, 32'h110, 5'd8, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 8'h03);
    #1 checkOutput("sw_rs2_nostall", 32'(stallId), 32'd0);
    tick();
    checkOutput("sw_rs2_valid", 32'(exValid), 32'd1);
    checkOutput("sw_rs2_memWrite", 32'(exMemWrite), 32'd1);
    checkOutput("sw_rs2_rnum2", 32'(exRnum2), 32'd5);
    checkOutput("sw_rs2_pc", exPc, 32'h110);

    // lw x5 then sw x7,0(x5): rs1 match stalls
    applyStimulus(1'b1, 32'h114, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    applyStimulus(1'b1, 32'h118, 5'd5, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 8'h03);
    #1 checkOutput("sw_rs1_stall", 32'(stallId), 32'd1);
    tick();
    checkOutput("sw_rs1_bub_valid", 32'(exValid), 32'd0);
    checkOutput("sw_rs1_bub_memWrite", 32'(exMemWrite), 32'd0);
    tick();
    checkOutput("sw_rs1_cap_pc", exPc, 32'h118);
    checkOutput("sw_rs1_cap_memWrite", 32'(exMemWrite), 32'd1);

    // lw x5 then dependent add with flush: flush wins, no stall
    applyStimulus(1'b1, 32'h11c, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    applyStimulus(1'b1, 32'h120, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'h01);
    flush = 1'b1;
    #1 checkOutput("flush_nostall", 32'(stallId), 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flush_valid", 32'(exValid), 32'd0);
    checkOutput("flush_wnum", 32'(exWnum), 32'd0);
    checkOutput("flush_pc", exPc, 32'd0);

    // lw x0 followed by a reader of x0: never stalls
    applyStimulus(1'b1, 32'h124, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    checkOutput("lwx0_memRead", 32'(exMemRead), 32'd1);
    applyStimulus(1'b1, 32'h128, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 8'h01);
    #1 checkOutput("x0_nostall", 32'(stallId), 32'd0);
    tick();
    checkOutput("x0_cap_pc", exPc, 32'h128);
    checkOutput("x0_cap_valid", 32'(exValid), 32'd1);

    // Hold for 3 cycles with a hazard pending: EX frozen, stall stays high
    applyStimulus(1'b1, 32'h12c, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    applyStimulus(1'b1, 32'h130, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'h01);
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("hold%0d_stall", i), 32'(stallId), 32'd1);
      tick();
      checkOutput($sformatf("hold%0d_pc", i), exPc, 32'h12c);
      checkOutput($sformatf("hold%0d_memRead", i), 32'(exMemRead), 32'd1);
      checkOutput($sformatf("hold%0d_valid", i), 32'(exValid), 32'd1);
    end
    hold = 1'b0;
    checkOutput("unhold_stall", 32'(stallId), 32'd1);
    tick();
    checkOutput("unhold_bub_valid", 32'(exValid), 32'd0);
    tick();
    checkOutput("unhold_cap_pc", exPc, 32'h130);

    // Back-to-back dependent loads: each stalls one cycle
    applyStimulus(1'b1, 32'h134, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    applyStimulus(1'b1, 32'h138, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 8'h02);
    #1 checkOutput("b2b1_stall", 32'(stallId), 32'd1);
    tick();
    checkOutput("b2b1_bub_valid", 32'(exValid), 32'd0);
    tick();
    checkOutput("b2b1_cap_pc", exPc, 32'h138);
    checkOutput("b2b1_cap_memRead", 32'(exMemRead), 32'd1);
    applyStimulus(1'b1, 32'h13c, 5'd6, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 8'h01);
    #1 checkOutput("b2b2_stall", 32'(stallId), 32'd1);
    tick();
    checkOutput("b2b2_bub_valid", 32'(exValid), 32'd0);
    tick();
    checkOutput("b2b2_cap_pc", exPc, 32'h13c);
    checkOutput("b2b2_cap_valid", 32'(exValid), 32'd1);

`ifdef ID_EX_PERF_CNT_EN
    checkOutput("bubble_cnt", bubbleCnt, 32'd5);
    checkOutput("flush_cnt", flushCnt, 32'd1);
`endif

    // Asynchronous reset between edges with EX valid
    #3 rstn = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(exValid), 32'd0);
    checkOutput("arst_pc", exPc, 32'd0);
    checkOutput("arst_wnum", 32'(exWnum), 32'd0);
    checkOutput("arst_ctrl", 32'(exCtrl), 32'd0);
    checkOutput("arst_stall", 32'(stallId), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("arst_bubble_cnt", bubbleCnt, 32'd0);
    checkOutput("arst_flush_cnt", flushCnt, 32'd0);
`endif
    #3 rstn = 1'b1;
    tick();
    checkOutput("post_rst_pc", exPc, 32'h13c);
    checkOutput("post_rst_valid", 32'(exValid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with built-in load-use hazard detection.
- Captures decoded operands, register numbers and control from ID each cycle.
- Presents the EX-stage view consumed by the ALU operand muxes and by the forwarding unit (o_EX_rnum1/2 feed its EX read-register inputs).
- Inserts bubbles on load-use hazards and on taken-branch flushes.

Parameters:
- XLEN, 32, datapath width for pc, operands and immediate.
- CTRL_W, 8, width of the opaque ALU/branch control bundle (ALU op, ALUSrc, branch type).

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_ID_valid  input  1  ID holds a real instruction.
- i_ID_pc  input  XLEN  instruction PC.
- i_ID_rdata1  input  XLEN  register file read data for rs1.
- i_ID_rdata2  input  XLEN  register file read data for rs2.
- i_ID_imm  input  XLEN  decoded immediate.
- i_ID_rnum1  input  5  rs1 number.
- i_ID_rnum2  input  5  rs2 number.
- i_ID_use_rs1  input  1  instruction actually reads rs1.
- i_ID_use_rs2  input  1  instruction actually reads rs2.
- i_ID_wnum  input  5  rd number.
- i_ID_wen  input  1  register write enable.
- i_ID_memRead  input  1  load.
- i_ID_memWrite  input  1  store.
- i_ID_ctrl  input  CTRL_W  ALU/branch control bundle.
- i_hold  input  1  downstream freeze (memory wait); all registers hold.
- i_flush  input  1  taken branch/jump resolved in EX; squash the ID instruction.
- o_EX_valid, o_EX_pc, o_EX_rdata1, o_EX_rdata2, o_EX_imm, o_EX_rnum1, o_EX_rnum2, o_EX_wnum, o_EX_wen, o_EX_memRead, o_EX_memWrite, o_EX_ctrl  output  (widths as the matching i_ID_*)  registered EX-stage copies.
- o_stall_ID  output  1  combinational; freezes the PC and IF/ID this cycle.

Behaviour:
- Reset (i_rstn=0, asynchronous): every o_EX_* register goes to 0, including o_EX_valid=0. The stage is then a bubble.
- Latency: 1 cycle from ID to EX.
- Hazard (combinational) is asserted when all of the following hold:
  - o_EX_valid & o_EX_memRead & (o_EX_wnum != 0) & i_ID_valid & !i_flush.
  - and either i_ID_use_rs1 & (i_ID_rnum1 == o_EX_wnum),
  - or i_ID_use_rs2 & (i_ID_rnum2 == o_EX_wnum) & !i_ID_memWrite.
- Store-data exception: a store whose only match is rs2 does not stall. The WB-to-MEM store-data forward covers that case. A store whose rs1 matches does stall.
- o_stall_ID = hazard. It is independent of i_hold.
- Register update priority at each rising edge:
  1. i_hold=1: all registers keep their value. This overrides flush and hazard; the pending flush is expected to be held asserted by EX.
  2. i_flush=1: load a bubble.
  3. hazard=1: load a bubble. ID is frozen externally via o_stall_ID.
  4. Otherwise: capture all i_ID_* fields, with o_EX_valid = i_ID_valid.
- Bubble contents: valid, wen, memRead, memWrite, ctrl, rnum1, rnum2 and wnum are all 0. Data fields (pc, rdata1/2, imm) are also 0 for determinism.
- A load-use stall lasts exactly one cycle: after the bubble, o_EX_memRead=0, so the hazard clears.
- Back-to-back loads that each use the previous load's rd stall one cycle each.
- rd = x0 never causes a stall.
- Reset asserted mid-stall: registers clear immediately, and o_stall_ID drops once o_EX_valid=0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, add output o_bubble_cnt (32 bits) and output o_flush_cnt (32 bits).
  - o_bubble_cnt counts edges where a hazard bubble was loaded (i_hold=0).
  - o_flush_cnt counts edges where a flush bubble was loaded (i_hold=0).
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset release, then ID=add x3,x1,x2 (valid) -> next edge: o_EX_valid=1, o_EX_wnum=3, o_EX_rnum1=1, o_EX_rnum2=2, o_stall_ID=0.
- EX=lw x5 and ID=add x6,x5,x7 -> o_stall_ID=1 for exactly 1 cycle; EX becomes a bubble (wen=0, valid=0); next edge captures the add.
- EX=lw x5 and ID=sw x5,0(x8) (rs2 match only) -> o_stall_ID=0; the sw is captured directly.
- EX=lw x5, ID=add x6,x5,x7, with i_flush=1 -> o_stall_ID=0; a bubble is loaded; flush counter +1 when the macro is defined.
- EX=lw x0 and ID uses x0 -> no stall. Also: i_hold=1 for 3 cycles while a hazard is present -> EX unchanged and o_stall_ID stays 1 throughout.
- Assert i_rstn=0 asynchronously mid-cycle with EX valid -> all o_EX_* are 0 before the next edge.
